// File: rtl/wt_pkg.sv
// wt_pkg: shared types, encodings and rotate helpers for the message schedule unit
package wt_pkg;
  typedef enum logic [1:0] {IDLE, LOAD2, RUN} state_e;
  localparam logic [1:0] SHA256 = 2'b00;
  localparam logic [1:0] SHA512 = 2'b01;
  localparam logic [1:0] SHA384 = 2'b10;
  localparam int WORDS256 = 64;
  localparam int WORDS512 = 80;
  localparam int DATA_W = 512;
  localparam int WORD_W = 64;
  function automatic logic is_sha512(input logic [1:0] t);
    return t != SHA256;
  endfunction
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
endpackage

// File: rtl/wt_sigma.sv
// wt_sigma: small-sigma s0/s1 for SHA-256 (low 32 bits, zero-extended) or SHA-512
module wt_sigma
  import wt_pkg::*;
(
  input  logic        is512,
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  output logic [63:0] s0,
  output logic [63:0] s1
);
  logic [31:0] a, b;
  assign a = x0[31:0];
  assign b = x1[31:0];
  always_comb begin
    s0 = is512 ? (ror64(x0, 1) ^ ror64(x0, 8) ^ (x0 >> 7))
               : {32'b0, ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3)};
    s1 = is512 ? (ror64(x1, 19) ^ ror64(x1, 61) ^ (x1 >> 6))
               : {32'b0, ror32(b, 17) ^ ror32(b, 19) ^ (b >> 10)};
  end
endmodule

// File: rtl/wt_unit.sv
// wt_unit: SHA-2 message schedule generator; streams W0..W63/W79 from a 16-word sliding window
module wt_unit
  import wt_pkg::*;
(
  input  logic              axi_aclk,
  input  logic              axi_resetn,
  input  logic [1:0]        sha_type,
  input  logic              en,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);
  state_e state_q, state_d;
  logic [WORD_W-1:0] w_q [16];
  logic [WORD_W-1:0] w_d [16];
  logic [6:0] cnt_q, cnt_d;
  logic is512_q, is512_d, last_q, last_d, rdy_q;
  logic [63:0] s0, s1, nxt;
  logic s_hs, m_hs, fin;

  // w_q[0] is the word on the bus; w_q[k] holds W_{t+k}
  wt_sigma u_sigma (.is512(is512_q), .x0(w_q[1]), .x1(w_q[14]), .s0(s0), .s1(s1));

  assign s_axis_tready = (state_q == IDLE && en && rdy_q) || state_q == LOAD2;
  assign m_axis_tvalid = state_q == RUN;
  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign fin = cnt_q == (is512_q ? 7'(WORDS512 - 1) : 7'(WORDS256 - 1));
  assign m_axis_tlast = m_axis_tvalid && fin && last_q;
  assign m_axis_tdata = w_q[0];
  assign nxt = s1 + w_q[9] + s0 + w_q[0];

  always_comb begin
    state_d = state_q;
    is512_d = is512_q;
    last_d = last_q;
    cnt_d = cnt_q;
    w_d = w_q;
    if (s_hs && state_q == IDLE) begin
      is512_d = is_sha512(sha_type);
      last_d = s_axis_tlast;
      cnt_d = '0;
      state_d = is512_d ? LOAD2 : RUN;
      for (int i = 0; i < 16; i++) w_d[i] = {32'b0, s_axis_tdata[511-32*i -: 32]};
      if (is512_d)
        for (int i = 0; i < 8; i++) w_d[i] = s_axis_tdata[511-64*i -: 64];
    end else if (s_hs) begin
      last_d = s_axis_tlast;
      state_d = RUN;
      for (int i = 0; i < 8; i++) w_d[i+8] = s_axis_tdata[511-64*i -: 64];
    end
    if (m_hs) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = is512_q ? nxt : {32'b0, nxt[31:0]};
      cnt_d = cnt_q + 7'd1;
      state_d = fin ? IDLE : RUN;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      is512_q <= 1'b0;
      last_q <= 1'b0;
      rdy_q <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      is512_q <= is512_d;
      last_q <= last_d;
      rdy_q <= 1'b1;
      w_q <= w_d;
    end
  end
endmodule

// File: tb/tb_wt_unit.sv
// tb_wt_unit: directed checks of the schedule stream against a reference recurrence
module tb_wt_unit;
  logic clk = 0, rstn = 0, en = 1, s_tvalid = 0, s_tlast = 0, m_tready = 0;
  logic [1:0] sha_type = 2'b00;
  logic [511:0] s_tdata = '0;
  logic s_tready, m_tvalid, m_tlast;
  logic [63:0] m_tdata;
  logic [63:0] exp_w [80];
  logic [63:0] got_w [80];
  logic cur512 = 0;
  int checks = 0, errors = 0;
  logic [511:0] abc256, abc512a, abc512b, pd;
  logic [7:0] pat;

  always #5 clk = ~clk;

  wt_unit dut (
    .axi_aclk(clk), .axi_resetn(rstn), .sha_type(sha_type), .en(en),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r32(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build(logic is512, logic [511:0] b1, logic [511:0] b2);
    logic [31:0] a, b, c, d;
    for (int t = 0; t < 80; t++) exp_w[t] = '0;
    if (is512) begin
      for (int i = 0; i < 8; i++) begin
        exp_w[i] = b1[511-64*i -: 64];
        exp_w[i+8] = b2[511-64*i -: 64];
      end
      for (int t = 16; t < 80; t++)
        exp_w[t] = (r64(exp_w[t-2], 19) ^ r64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6)) + exp_w[t-7]
                 + (r64(exp_w[t-15], 1) ^ r64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7)) + exp_w[t-16];
    end else begin
      for (int i = 0; i < 16; i++) exp_w[i] = {32'b0, b1[511-32*i -: 32]};
      for (int t = 16; t < 64; t++) begin
        a = exp_w[t-2][31:0]; b = exp_w[t-15][31:0];
        c = exp_w[t-7][31:0]; d = exp_w[t-16][31:0];
        exp_w[t] = {32'b0, (r32(a, 17) ^ r32(a, 19) ^ (a >> 10)) + c + (r32(b, 7) ^ r32(b, 18) ^ (b >> 3)) + d};
      end
    end
  endtask

  task automatic send_beat(logic [511:0] d, logic l);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait", 64'(n >= 50), 0);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic send_block(logic [1:0] ty, logic [511:0] b1, logic [511:0] b2, logic l);
    cur512 = ty != 2'b00;
    build(cur512, b1, b2);
    sha_type = ty;
    if (cur512) begin
      send_beat(b1, ~l);
      sha_type = 2'b00;
      send_beat(b2, l);
    end else
      send_beat(b1, l);
    sha_type = cur512 ? 2'b00 : 2'b01;
  endtask

  task automatic collect(int n, logic rnd, logic exp_last);
    int idx = 0, cyc = 0, total;
    logic stalled = 0;
    logic [63:0] held = '0;
    total = cur512 ? 80 : 64;
    check("valid_lat", m_tvalid, 1);
    check("s_rdy_run", s_tready, 0);
    while (idx < n && cyc < 3000) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) check("hold", m_tdata, held);
      if (m_tvalid && m_tready) begin
        got_w[idx] = m_tdata;
        check($sformatf("w%0d", idx), m_tdata, exp_w[idx]);
        check($sformatf("tlast%0d", idx), m_tlast, 64'(exp_last && idx == total - 1));
        idx++;
      end
      stalled = m_tvalid && !m_tready;
      held = m_tdata;
      @(negedge clk);
      cyc++;
    end
    check("collect_count", idx, n);
    if (n == total) check("done_valid", m_tvalid, 0);
  endtask

  initial begin
    abc256 = {32'h61626380, 448'b0, 32'h00000018};
    abc512a = {64'h6162638000000000, 448'b0};
    abc512b = {448'b0, 64'h18};
    pat = 8'b11010011;
    @(negedge clk);
    check("rst_s_rdy", s_tready, 0);
    check("rst_m_valid", m_tvalid, 0);
    check("rst_m_data", m_tdata, 0);
    check("rst_m_last", m_tlast, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    check("rdy_after_rst", s_tready, 1);

    send_block(2'b00, abc256, '0, 1);
    collect(64, 0, 1);
    check("a_w0", got_w[0], 64'h61626380);
    check("a_w15", got_w[15], 64'h18);
    check("a_w16", got_w[16], 64'h61626380);
    check("a_w17", got_w[17], 64'h000F0000);

    send_block(2'b01, abc512a, abc512b, 0);
    collect(80, 0, 0);
    check("b_w0", got_w[0], 64'h6162638000000000);
    check("b_w15", got_w[15], 64'h18);
    check("b_w16", got_w[16], 64'h6162638000000000);
    check("b_w17", got_w[17], 64'h00030000000000C0);

    send_block(2'b00, abc256, '0, 1);
    en = 0;
    collect(64, 1, 1);
    check("c_w17", got_w[17], 64'h000F0000);

    @(negedge clk);
    check("d_rdy_en0", s_tready, 0);
    s_tvalid = 1;
    repeat (5) @(negedge clk);
    check("d_no_out", m_tvalid, 0);
    s_tvalid = 0;
    en = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (pat[i]) begin
        for (int j = 0; j < 8; j++) pd[511-64*j -: 64] = 64'(i * 8 + j + 1);
        send_block(2'b00, pd, '0, i == 7);
        collect(64, 0, i == 7);
      end else
        @(negedge clk);
    end

    send_block(2'b00, abc256, '0, 1);
    collect(10, 0, 1);
    #2 rstn = 0;
    #1;
    check("f_rst_valid", m_tvalid, 0);
    check("f_rst_data", m_tdata, 0);
    check("f_rst_last", m_tlast, 0);
    check("f_rst_rdy", s_tready, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    check("f_idle_valid", m_tvalid, 0);
    send_block(2'b10, abc512a, abc512b, 1);
    collect(80, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
